clk_divider_multi: RTL and testbench
====================================

# clk_divider_multi

Parametrised multi-channel clock/tick divider. Each channel produces a divided clock with a runtime-programmable period and high time, plus a one-cycle tick at each period start. It replaces fixed single-rate dividers such as the 20 ms simulation-step divider. Motor PWM, display scan and step timing channels are all driven from one block. Period changes take effect only at period boundaries, so no output ever has a glitch or a truncated phase.

## Interface
- CH, 4: number of channels (≥1).
- W, 24: counter, period and high-time width.
- RESET_PERIOD, 2000000: period per channel after reset, in clk cycles (20 ms at 100 MHz).
- RESET_HIGH, 1000000: high time per channel after reset, in clk cycles.
- CW, derived: max(1, clog2(CH)). This is not user-set.

- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- en  in  CH  per-channel run enable.
- cfg_valid  in  1  config write request.
- cfg_ready  out  1  config write can be accepted (combinational).
- cfg_ch  in  CW  target channel.
- cfg_period  in  W  new period P, in cycles.
- cfg_high  in  W  new high time H, in cycles.
- cfg_err  out  1  one-cycle pulse when an accepted write is rejected as invalid.
- divided_clk  out  CH  divided clocks, registered.
- tick  out  CH  period-start pulses, registered.

## Operation
- Per-channel state:
  - counter cnt[W]
  - active P_a, H_a
  - pending P_p, H_p
  - flag pend
- Reset (rst=0) values:
  - cnt=RESET_PERIOD-1, P_a=RESET_PERIOD, H_a=RESET_HIGH.
  - pend=0, divided_clk=0, tick=0, cfg_err=0.
  - cfg_ready=1.
- Handshake:
  - cfg_ready = !pend[cfg_ch]. If cfg_ch ≥ CH, cfg_ready=1.
  - A transfer happens on a clk edge where cfg_valid && cfg_ready.
- Validity rules:
  - A write is valid iff cfg_ch < CH, cfg_period ≥ 2 and cfg_high ≤ cfg_period.
  - H=0 gives a constant-low output with ticks. H=P gives a constant-high output with ticks.
- Valid transfer: P_p ← cfg_period, H_p ← cfg_high, pend ← 1.
- Invalid transfer: cfg_err=1 for the next cycle only. No channel state changes.
- Enabled channel (en[i]=1), each edge:
  - Wrap condition is cnt==P_a-1.
  - On wrap: cnt ← 0. If pend was already set before this edge, also P_a ← P_p, H_a ← H_p, pend ← 0.
  - Otherwise: cnt ← cnt+1.
  - divided_clk[i] ← (cnt_next < H_next). H_next is the newly loaded H if a load occurs on this edge.
  - tick[i] ← (cnt_next == 0).
- Disabled channel (en[i]=0), each edge:
  - divided_clk[i] ← 0, tick[i] ← 0.
  - If pend: load P_a/H_a from pending, clear pend.
  - cnt ← P_a_next-1, so the first enabled edge wraps and starts a fresh period.
- Channels are fully independent. At most one config transfer happens per cycle.

## Timing
- Tick latency: the first edge with en[i] sampled 1 after reset or disable sets tick=1 and divided_clk=(H_a>0). Both are visible after that edge.
- Steady state:
  - tick[i] is high exactly 1 cycle in every P_a cycles.
  - divided_clk[i] is high for the first H_a cycles of each period and low for the remaining P_a-H_a.
- Config latency, enabled channel: new values govern the period that starts at the first wrap after the transfer edge.
  - A transfer on the wrap edge itself does not affect that wrap. It applies at the next wrap.
- Config latency, disabled channel: the pending load happens on the edge after the transfer. cfg_ready for that channel returns to 1 one cycle after the transfer.
- Back-pressure: a second write to a channel with pend=1 stalls (cfg_ready=0) until its wrap edge. cfg_ready rises in the cycle after that edge.
- en toggled mid-period: outputs go low on the next edge and the partial period is abandoned. Re-enable always starts a full period.
- Asynchronous reset mid-period forces all outputs to 0 immediately and discards pending configs.
- Width rule: all compares and increments are unsigned W-bit. P ≤ 2^W-1, so cnt never overflows.

## Test plan
- Reset then en=all-1 with defaults, 100 MHz: tick[0] at the first edge and then every 2,000,000 cycles. divided_clk high 1,000,000 cycles, low 1,000,000.
- Channel 1, write P=5, H=2 while enabled: the old period completes, then divided_clk[1] shows pattern 11000 repeating with tick on the first '1'. A second write P=4, H=4 issued immediately sees cfg_ready=0 until the wrap, then gives a constant-high output with a tick every 4 cycles.
- Write P=1, H=0, then P=6, H=7: each gets cfg_ready=1, a cfg_err pulse one cycle later, and unchanged outputs.
- Channel 2 disabled, write P=3, H=1, then raise en[2]: tick and divided_clk rise on the first enabled edge, then pattern 100 repeats. Drop en mid-high: output low next edge.
- Write to channel 0 on its exact wrap edge (P=4→8, H=2→3): the wrap uses P=4, the following period is still 4, and the 8/3 pattern starts at the next wrap.
- Assert rst mid-period with a pending config on channel 3: outputs 0 immediately, pend cleared, and after release P/H equal the reset defaults.

Source files
------------

// File: rtl/clk_divider_multi.sv
// clk_divider_multi: multi-channel programmable clock/tick divider.
// Config writes are staged per channel and applied only at period boundaries.

module clk_div_chan #(
  parameter int W            = 24,
  parameter int RESET_PERIOD = 2000000,
  parameter int RESET_HIGH   = 1000000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] new_period,
  input  logic [W-1:0] new_high,
  output logic         pend,
  output logic         divided_clk,
  output logic         tick
);

  localparam logic [W-1:0] RP  = W'(RESET_PERIOD);
  localparam logic [W-1:0] RH  = W'(RESET_HIGH);
  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] cnt;
  logic [W-1:0] p_a;
  logic [W-1:0] h_a;
  logic [W-1:0] p_p;
  logic [W-1:0] h_p;
  logic [W-1:0] cnt_nx;
  logic [W-1:0] p_nx;
  logic [W-1:0] h_nx;
  logic         wrap;
  logic         take;
  logic         pend_nx;

  // Staged values swap in on a wrap, or on any idle edge while disabled.
  always_comb begin
    wrap    = (cnt == p_a - ONE);
    take    = pend && (!en || wrap);
    p_nx    = take ? p_p : p_a;
    h_nx    = take ? h_p : h_a;
    pend_nx = (pend && !take) || load;
    cnt_nx  = cnt;
    unique case (1'b1)
      !en:         cnt_nx = p_nx - ONE;
      en && wrap:  cnt_nx = '0;
      en && !wrap: cnt_nx = cnt + ONE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt         <= RP - ONE;
      p_a         <= RP;
      h_a         <= RH;
      p_p         <= RP;
      h_p         <= RH;
      pend        <= 1'b0;
      divided_clk <= 1'b0;
      tick        <= 1'b0;
    end else begin
      cnt         <= cnt_nx;
      p_a         <= p_nx;
      h_a         <= h_nx;
      pend        <= pend_nx;
      if (load) begin
        p_p <= new_period;
        h_p <= new_high;
      end
      divided_clk <= en && (cnt_nx < h_nx);
      tick        <= en && (cnt_nx == '0);
    end
  end

endmodule

module clk_divider_multi #(
  parameter int  CH           = 4,
  parameter int  W            = 24,
  parameter int  RESET_PERIOD = 2000000,
  parameter int  RESET_HIGH   = 1000000,
  localparam int CW           = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] en,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [CW-1:0] cfg_ch,
  input  logic [W-1:0]  cfg_period,
  input  logic [W-1:0]  cfg_high,
  output logic          cfg_err,
  output logic [CH-1:0] divided_clk,
  output logic [CH-1:0] tick
);

  logic [CH-1:0] pend;
  logic [CH-1:0] load;
  logic          ch_ok;
  logic          wr_ok;
  logic          xfer;

  assign ch_ok = (int'(cfg_ch) < CH);
  assign wr_ok = ch_ok
              && (cfg_period >= W'(2))
              && (cfg_high <= cfg_period);
  // Out-of-range channels always accept so the error pulse can report them.
  assign cfg_ready = !ch_ok || !pend[cfg_ch];
  assign xfer      = cfg_valid && cfg_ready;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    assign load[i] = xfer && wr_ok && (int'(cfg_ch) == i);

    clk_div_chan #(
      .W            (W),
      .RESET_PERIOD (RESET_PERIOD),
      .RESET_HIGH   (RESET_HIGH)
    ) u_chan (
      .clk         (clk),
      .rst         (rst),
      .en          (en[i]),
      .load        (load[i]),
      .new_period  (cfg_period),
      .new_high    (cfg_high),
      .pend        (pend[i]),
      .divided_clk (divided_clk[i]),
      .tick        (tick[i])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= xfer && !wr_ok;
    end
  end

endmodule

// File: tb/tb_clk_divider_multi.sv
// Scoreboard bench for clk_divider_multi against a
// period/phase reference model of each channel.

module tb_clk_divider_multi;

  localparam int CH = 4;
  localparam int W  = 8;
  localparam int RP = 12;
  localparam int RH = 5;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] en;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [CW-1:0] cfg_ch;
  logic [W-1:0]  cfg_period;
  logic [W-1:0]  cfg_high;
  logic          cfg_err;
  logic [CH-1:0] divided_clk;
  logic [CH-1:0] tick;

  clk_divider_multi #(
    .CH           (CH),
    .W            (W),
    .RESET_PERIOD (RP),
    .RESET_HIGH   (RH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_ch      (cfg_ch),
    .cfg_period  (cfg_period),
    .cfg_high    (cfg_high),
    .cfg_err     (cfg_err),
    .divided_clk (divided_clk),
    .tick        (tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CH-1:0] dclk;
    logic [CH-1:0] tk;
    logic          err;
    logic          rdy;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference: each channel is a sequence of periods; ph is the
  // position inside the current one, run=0 means no period open.
  int            pa[CH];
  int            ha[CH];
  int            pp[CH];
  int            hp[CH];
  int            ph[CH];
  bit            pend[CH];
  bit            run[CH];
  logic [CH-1:0] m_clk;
  logic [CH-1:0] m_tick;
  logic          m_err;

  function automatic void chk(string name, logic [31:0] got,
                              logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, got, want, $time);
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < CH; i++) begin
      pa[i]   = RP;
      ha[i]   = RH;
      pp[i]   = RP;
      hp[i]   = RH;
      ph[i]   = 0;
      pend[i] = 1'b0;
      run[i]  = 1'b0;
    end
    m_clk  = '0;
    m_tick = '0;
    m_err  = 1'b0;
  endfunction

  function automatic bit model_ready(int c);
    return (c >= CH) || !pend[c];
  endfunction

  function automatic void model_edge();
    int c;
    int p;
    int h;
    bit xfer;
    bit pb[CH];
    c    = int'(cfg_ch);
    p    = int'(cfg_period);
    h    = int'(cfg_high);
    xfer = cfg_valid && model_ready(c);
    pb   = pend;
    for (int i = 0; i < CH; i++) begin
      if (!en[i]) begin
        run[i]    = 1'b0;
        m_clk[i]  = 1'b0;
        m_tick[i] = 1'b0;
        if (pb[i]) begin
          pa[i]   = pp[i];
          ha[i]   = hp[i];
          pend[i] = 1'b0;
        end
      end else begin
        if (!run[i] || ph[i] + 1 == pa[i]) begin
          ph[i] = 0;
          if (pb[i]) begin
            pa[i]   = pp[i];
            ha[i]   = hp[i];
            pend[i] = 1'b0;
          end
        end else begin
          ph[i] = ph[i] + 1;
        end
        run[i]    = 1'b1;
        m_clk[i]  = (ph[i] < ha[i]);
        m_tick[i] = (ph[i] == 0);
      end
    end
    m_err = 1'b0;
    if (xfer) begin
      if (c < CH && p >= 2 && h <= p) begin
        pp[c]   = p;
        hp[c]   = h;
        pend[c] = 1'b1;
      end else begin
        m_err = 1'b1;
      end
    end
  endfunction

  task automatic drive(input logic [CH-1:0] e, input logic v,
                       input int c, input int p, input int h);
    en         = e;
    cfg_valid  = v;
    cfg_ch     = CW'(c);
    cfg_period = W'(p);
    cfg_high   = W'(h);
    q.push_back('{m_clk, m_tick, m_err, model_ready(c)});
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input logic [CH-1:0] e, input int n);
    for (int k = 0; k < n; k++) drive(e, 1'b0, 0, 0, 0);
  endtask

  task automatic write_hold(input logic [CH-1:0] e, input int c,
                            input int p, input int h);
    for (int k = 0; k < 64; k++) begin
      if (model_ready(c)) begin
        drive(e, 1'b1, c, p, h);
        return;
      end
      drive(e, 1'b0, c, p, h);
    end
    checks++;
    errors++;
    $display("FAIL write_hold ch%0d timeout", c);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("divided_clk", 32'(divided_clk), 32'(e.dclk));
        chk("tick", 32'(tick), 32'(e.tk));
        chk("cfg_err", 32'(cfg_err), 32'(e.err));
        chk("cfg_ready", 32'(cfg_ready), 32'(e.rdy));
      end
    end
  end

  initial begin : stim
    logic [CH-1:0] cur;
    bit            found;
    int            p;
    int            h;
    rst        = 1'b0;
    en         = '0;
    cfg_valid  = 1'b0;
    cfg_ch     = '0;
    cfg_period = '0;
    cfg_high   = '0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_divided_clk", 32'(divided_clk), 32'(0));
    chk("rst_tick", 32'(tick), 32'(0));
    chk("rst_cfg_err", 32'(cfg_err), 32'(0));
    chk("rst_cfg_ready", 32'(cfg_ready), 32'(1));
    rst = 1'b1;

    idle(4'hF, 30);
    write_hold(4'hF, 1, 5, 2);
    write_hold(4'hF, 1, 4, 4);
    idle(4'hF, 20);
    write_hold(4'hF, 0, 1, 0);
    write_hold(4'hF, 0, 6, 7);
    idle(4'hF, 4);

    idle(4'b1011, 4);
    write_hold(4'b1011, 2, 3, 1);
    idle(4'b1011, 2);
    idle(4'hF, 7);
    idle(4'b1011, 3);
    idle(4'hF, 6);

    write_hold(4'hF, 0, 4, 2);
    idle(4'hF, 20);
    found = 1'b0;
    for (int k = 0; k < 64 && !found; k++) begin
      if (run[0] && ph[0] == pa[0] - 1 && !pend[0]) begin
        drive(4'hF, 1'b1, 0, 8, 3);
        found = 1'b1;
      end else begin
        drive(4'hF, 1'b0, 0, 0, 0);
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL wrap_edge_write timeout");
    end
    idle(4'hF, 30);

    cur = 4'hF;
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < CH; i++)
        if ($urandom_range(0, 39) == 0) cur[i] = ~cur[i];
      p = int'($urandom_range(0, 14));
      h = int'($urandom_range(0, p + 1));
      drive(cur, ($urandom_range(0, 4) == 0),
            int'($urandom_range(0, CH - 1)), p, h);
    end

    idle(4'hF, 4);
    write_hold(4'hF, 3, 15, 7);
    cfg_valid = 1'b0;
    cfg_ch    = 2'd3;
    rst       = 1'b0;
    #1;
    chk("mid_rst_divided_clk", 32'(divided_clk), 32'(0));
    chk("mid_rst_tick", 32'(tick), 32'(0));
    chk("mid_rst_cfg_err", 32'(cfg_err), 32'(0));
    chk("mid_rst_cfg_ready", 32'(cfg_ready), 32'(1));
    model_reset();
    #2;
    rst = 1'b1;
    idle(4'hF, 30);

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
